// File: rtl/ifetch_pkg.sv
// Shared constants and types for the instruction-fetch unit.
// A fetch-queue entry pairs an instruction with the address it was fetched from.
package ifetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          INST_WIDTH       = 32;
    localparam int          FQ_ENTRY_W       = 2 * INST_WIDTH;
    localparam logic [31:0] PC_STEP          = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fq_entry_t;

    // Instruction addresses are word aligned; the low two bits are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous fetch queue with flush.
// Storage is registered, so the head never depends combinationally on the write data.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic [FQ_ENTRY_W-1:0] push_data,
    input  logic                  pop,
    output logic [FQ_ENTRY_W-1:0] head_data,
    output logic [AW:0]           count,
    output logic                  empty
);

    logic [FQ_ENTRY_W-1:0] mem_q [DEPTH];
    logic [FQ_ENTRY_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Flush only resets bookkeeping; stale data is unreachable once count is zero.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign empty     = (count_q == '0);

endmodule

// File: rtl/ifetch.sv
// Instruction-fetch initiator: PC register, fetch/redirect control and a small
// queue of {pc, instruction} pairs handed to decode over valid/ready.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          FQ_DEPTH = 2,
    parameter int          FQ_AW    = 1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] iaddr,
    input  logic [31:0] idata,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc
);

    // Handshake: an entry transfers on any cycle where out_valid and out_ready
    // are both high; out_valid and the head stay put until that happens,
    // except that a redirect flushes the queue unconditionally.

    logic [31:0]           pc_q, pc_d;
    logic                  pop, push;
    logic                  fq_empty;
    logic [FQ_AW:0]        fq_count;
    logic [FQ_ENTRY_W-1:0] head_data;
    fq_entry_t             push_entry;
    fq_entry_t             head_entry;

    assign pop  = out_valid & out_ready;
    // A full queue still accepts a fetch when decode drains the head this cycle.
    assign push = fetch_en & ~redirect_valid &
                  ((fq_count < (FQ_AW+1)'(FQ_DEPTH)) | pop);

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = align_pc(redirect_pc);
        end else if (push) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign push_entry = '{pc: pc_q, inst: idata};

    ifetch_fifo #(
        .DEPTH (FQ_DEPTH),
        .AW    (FQ_AW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_data),
        .count     (fq_count),
        .empty     (fq_empty)
    );

    assign head_entry = fq_entry_t'(head_data);
    assign iaddr      = pc_q;
    assign out_valid  = ~fq_empty;
    assign out_pc     = head_entry.pc;
    assign out_inst   = head_entry.inst;

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: a queue-based reference model tracks what
// decode should see, driven by directed scenarios and a randomized run.
module tb_ifetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] iaddr;
    logic [31:0] idata;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: entries decode will see, oldest first, and the model PC.
    logic [63:0] exp_q[$];
    logic [31:0] m_pc;

    localparam int MODEL_DEPTH = 2;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA000_0000 | a;
    endfunction

    always_comb idata = mem_word(iaddr);

    ifetch dut (
        .clk            (clk),
        .rst            (rst),
        .iaddr          (iaddr),
        .idata          (idata),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc)
    );

    task automatic model_reset();
        exp_q.delete();
        m_pc = 32'h0000_0000;
    endtask

    // Drive one cycle of inputs from a negedge, advance the model by the
    // rules of the fetch unit, and return at the following negedge.
    task automatic step(input logic fe, input logic rv, input logic [31:0] rpc, input logic rdy);
        logic pop_m;
        logic push_m;
        fetch_en       = fe;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        pop_m  = (exp_q.size() > 0) && rdy;
        push_m = 1'b0;
        if (rv) begin
            exp_q.delete();
            m_pc = rpc & 32'hFFFF_FFFC;
        end else begin
            push_m = fe && ((exp_q.size() < MODEL_DEPTH) || pop_m);
            if (pop_m) void'(exp_q.pop_front());
            if (push_m) begin
                exp_q.push_back({m_pc, mem_word(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        fetch_en = 1'b0;
        redirect_valid = 1'b0;
        out_ready = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_inst !== 32'h0 || iaddr !== 32'h0) begin
            miscompares++;
            $display("FAIL reset got v=%b pc=%h inst=%h iaddr=%h exp v=0 pc=0 inst=0 iaddr=0",
                     out_valid, out_pc, out_inst, iaddr);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_stream();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1);
            vectors++;
            if (out_valid !== 1'b1 || out_pc !== 32'(i * 4) || out_inst !== mem_word(32'(i * 4)) ||
                iaddr !== m_pc) begin
                miscompares++;
                $display("FAIL stream i=%0d got v=%b pc=%h inst=%h iaddr=%h exp pc=%h iaddr=%h",
                         i, out_valid, out_pc, out_inst, iaddr, 32'(i * 4), m_pc);
            end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b0);
            if (i >= 1) begin
                vectors++;
                if (out_valid !== 1'b1 || out_pc !== 32'h0 || iaddr !== 32'h8) begin
                    miscompares++;
                    $display("FAIL backpressure_hold i=%0d got v=%b pc=%h iaddr=%h exp v=1 pc=0 iaddr=8",
                             i, out_valid, out_pc, iaddr);
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_pc !== 32'(i * 4) || out_inst !== mem_word(32'(i * 4))) begin
                miscompares++;
                $display("FAIL backpressure_release i=%0d got v=%b pc=%h inst=%h exp pc=%h",
                         i, out_valid, out_pc, out_inst, 32'(i * 4));
            end
            step(1'b1, 1'b0, 32'h0, 1'b1);
        end
    endtask

    task automatic test_redirect_full();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 32'h0000_0100, 1'b0);
        vectors++;
        if (out_valid !== 1'b0 || iaddr !== 32'h100) begin
            miscompares++;
            $display("FAIL redirect_flush got v=%b iaddr=%h exp v=0 iaddr=100", out_valid, iaddr);
        end
        step(1'b1, 1'b0, 32'h0, 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_inst !== 32'hA000_0100) begin
            miscompares++;
            $display("FAIL redirect_first got v=%b pc=%h inst=%h exp v=1 pc=100 inst=a0000100",
                     out_valid, out_pc, out_inst);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            vectors++;
            if (out_valid !== (exp_q.size() != 0) || iaddr !== m_pc ||
                (exp_q.size() != 0 && {out_pc, out_inst} !== exp_q[0])) begin
                miscompares++;
                $display("FAIL redirect_drain i=%0d got v=%b pc=%h inst=%h iaddr=%h exp n=%0d iaddr=%h",
                         i, out_valid, out_pc, out_inst, iaddr, exp_q.size(), m_pc);
            end
        end
    endtask

    task automatic test_unaligned_redirect();
        step(1'b1, 1'b1, 32'h0000_0103, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        vectors++;
        if (out_valid !== 1'b1 || out_pc !== 32'h100) begin
            miscompares++;
            $display("FAIL unaligned_redirect got v=%b pc=%h exp v=1 pc=100", out_valid, out_pc);
        end
    endtask

    task automatic test_full_pop_push();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1);
            vectors++;
            if (out_valid !== 1'b1 || iaddr !== out_pc + 32'd8 ||
                exp_q.size() != 2 || {out_pc, out_inst} !== exp_q[0] || iaddr !== m_pc) begin
                miscompares++;
                $display("FAIL full_pop_push i=%0d got v=%b pc=%h inst=%h iaddr=%h exp n=2 iaddr=%h",
                         i, out_valid, out_pc, out_inst, iaddr, m_pc);
            end
        end
    endtask

    task automatic test_wrap();
        step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        vectors++;
        if (out_valid !== 1'b1 || out_pc !== 32'hFFFF_FFFC || out_inst !== 32'hFFFF_FFFC) begin
            miscompares++;
            $display("FAIL wrap_last got v=%b pc=%h inst=%h exp pc=fffffffc", out_valid, out_pc, out_inst);
        end
        step(1'b1, 1'b0, 32'h0, 1'b1);
        vectors++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_inst !== 32'hA000_0000) begin
            miscompares++;
            $display("FAIL wrap_zero got v=%b pc=%h inst=%h exp pc=0 inst=a0000000",
                     out_valid, out_pc, out_inst);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_inst !== 32'h0 || iaddr !== 32'h0) begin
            miscompares++;
            $display("FAIL async_reset got v=%b pc=%h inst=%h iaddr=%h exp all zero",
                     out_valid, out_pc, out_inst, iaddr);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1);
            vectors++;
            if (out_valid !== 1'b1 || out_pc !== 32'(i * 4) || iaddr !== m_pc) begin
                miscompares++;
                $display("FAIL async_restart i=%0d got v=%b pc=%h iaddr=%h exp pc=%h iaddr=%h",
                         i, out_valid, out_pc, iaddr, 32'(i * 4), m_pc);
            end
        end
    endtask

    task automatic test_random();
        logic        fe;
        logic        rv;
        logic        rdy;
        logic [31:0] rpc;
        for (int i = 0; i < 400; i++) begin
            fe  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            rv  = ($urandom_range(0, 11) == 0);
            rpc = $urandom;
            step(fe, rv, rpc, rdy);
            vectors++;
            if (out_valid !== (exp_q.size() != 0) || iaddr !== m_pc ||
                (exp_q.size() != 0 && {out_pc, out_inst} !== exp_q[0])) begin
                miscompares++;
                $display("FAIL random i=%0d got v=%b pc=%h inst=%h iaddr=%h exp n=%0d iaddr=%h",
                         i, out_valid, out_pc, out_inst, iaddr, exp_q.size(), m_pc);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_full();
        test_unaligned_redirect();
        test_full_pop_push();
        test_wrap();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
